// File: rtl/i2c_target_regs_if.sv
// ============================================================================
// Module   : i2c_target_regs_if
// Brief    : I2C bus levels and register-file port of the I2C target.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface i2c_target_regs_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       stop_pulse;

  modport slave (
    input  scl_in, sda_in, reg_rdata,
    output sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy, stop_pulse
  );

  modport master (
    output scl_in, sda_in, reg_rdata,
    input  sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy, stop_pulse
  );
endinterface

`default_nettype wire

// File: rtl/i2c_target_regs.sv
// ============================================================================
// Module   : i2c_target_regs
// Brief    : Oversampled I2C target with auto-incrementing register pointer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_target_regs #(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int         FILTER_LEN  = 5
) (
  input  logic              system_clk,
  input  logic              reset,
  i2c_target_regs_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    PTR       = 4'd3,
    PTR_ACK   = 4'd4,
    WDATA     = 4'd5,
    WDATA_ACK = 4'd6,
    RDATA     = 4'd7,
    RDATA_ACK = 4'd8,
    IGNORE    = 4'd9
  } state_t;

  logic [1:0]            scl_s_q, sda_s_q;
  logic [FILTER_LEN-1:0] scl_w_q, sda_w_q;
  logic                  scl_f_q, sda_f_q, scl_p_q, sda_p_q;

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      scl_s_q <= '1;
      sda_s_q <= '1;
      scl_w_q <= '1;
      sda_w_q <= '1;
      scl_f_q <= 1'b1;
      sda_f_q <= 1'b1;
      scl_p_q <= 1'b1;
      sda_p_q <= 1'b1;
    end else begin
      scl_s_q <= {scl_s_q[0], bus.scl_in};
      sda_s_q <= {sda_s_q[0], bus.sda_in};
      scl_w_q <= {scl_w_q[FILTER_LEN-2:0], scl_s_q[1]};
      sda_w_q <= {sda_w_q[FILTER_LEN-2:0], sda_s_q[1]};
      // Filtered level moves only on a unanimous window.
      if (&scl_w_q)       scl_f_q <= 1'b1;
      else if (~|scl_w_q) scl_f_q <= 1'b0;
      if (&sda_w_q)       sda_f_q <= 1'b1;
      else if (~|sda_w_q) sda_f_q <= 1'b0;
      scl_p_q <= scl_f_q;
      sda_p_q <= sda_f_q;
    end
  end

  logic start_det, stop_det, rise, fall;
  assign start_det = scl_p_q & scl_f_q &  sda_p_q & ~sda_f_q;
  assign stop_det  = scl_p_q & scl_f_q & ~sda_p_q &  sda_f_q;
  assign rise      = ~scl_p_q &  scl_f_q;
  assign fall      =  scl_p_q & ~scl_f_q;

  state_t     state_q;
  logic [3:0] bitcnt_q;
  logic [7:0] shift_q, ptr_q, reg_wdata_q;
  logic       rw_q, cap_q, sda_oe_q, reg_we_q, reg_re_q, busy_q, stop_pulse_q;
  logic [7:0] byte_in;
  assign byte_in = {shift_q[6:0], sda_f_q};

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      bitcnt_q     <= 4'd0;
      shift_q      <= 8'd0;
      ptr_q        <= 8'd0;
      reg_wdata_q  <= 8'd0;
      rw_q         <= 1'b0;
      cap_q        <= 1'b0;
      sda_oe_q     <= 1'b0;
      reg_we_q     <= 1'b0;
      reg_re_q     <= 1'b0;
      busy_q       <= 1'b0;
      stop_pulse_q <= 1'b0;
    end else begin
      reg_we_q     <= 1'b0;
      reg_re_q     <= 1'b0;
      stop_pulse_q <= 1'b0;
      cap_q        <= reg_re_q;
      // Read data returns one cycle after the request; the pointer follows it.
      if (cap_q) begin
        shift_q <= bus.reg_rdata;
        ptr_q   <= ptr_q + 8'd1;
      end
      if (reg_we_q) ptr_q <= ptr_q + 8'd1;

      if (stop_det) begin
        state_q      <= IDLE;
        sda_oe_q     <= 1'b0;
        busy_q       <= 1'b0;
        stop_pulse_q <= busy_q;
      end else if (start_det) begin
        state_q  <= ADDR;
        bitcnt_q <= 4'd0;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          ADDR, PTR, WDATA: begin
            if (rise && bitcnt_q < 4'd8) begin
              shift_q  <= byte_in;
              bitcnt_q <= bitcnt_q + 4'd1;
              if (bitcnt_q == 4'd7) begin
                if (state_q == ADDR) begin
                  if (byte_in[7:1] == TARGET_ADDR) begin
                    busy_q <= 1'b1;
                    rw_q   <= byte_in[0];
                  end else begin
                    state_q <= IGNORE;
                  end
                end else if (state_q == PTR) begin
                  ptr_q <= byte_in;
                end else begin
                  reg_we_q    <= 1'b1;
                  reg_wdata_q <= byte_in;
                end
              end
            end else if (fall && bitcnt_q == 4'd8) begin
              sda_oe_q <= 1'b1;
              state_q  <= (state_q == ADDR) ? ADDR_ACK :
                          (state_q == PTR)  ? PTR_ACK  : WDATA_ACK;
            end
          end
          ADDR_ACK: begin
            if (rise) begin
              if (rw_q) reg_re_q <= 1'b1;
            end else if (fall) begin
              if (rw_q) begin
                sda_oe_q <= ~shift_q[7];
                bitcnt_q <= 4'd1;
                state_q  <= RDATA;
              end else begin
                sda_oe_q <= 1'b0;
                bitcnt_q <= 4'd0;
                state_q  <= PTR;
              end
            end
          end
          PTR_ACK, WDATA_ACK: begin
            if (fall) begin
              sda_oe_q <= 1'b0;
              bitcnt_q <= 4'd0;
              state_q  <= WDATA;
            end
          end
          RDATA: begin
            if (fall) begin
              if (bitcnt_q == 4'd8) begin
                sda_oe_q <= 1'b0;
                state_q  <= RDATA_ACK;
              end else begin
                sda_oe_q <= ~shift_q[6];
                shift_q  <= {shift_q[6:0], 1'b0};
                bitcnt_q <= bitcnt_q + 4'd1;
              end
            end
          end
          RDATA_ACK: begin
            if (rise) begin
              if (sda_f_q) state_q  <= IGNORE;
              else         reg_re_q <= 1'b1;
            end else if (fall) begin
              sda_oe_q <= ~shift_q[7];
              bitcnt_q <= 4'd1;
              state_q  <= RDATA;
            end
          end
          IDLE, IGNORE: ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.sda_oe     = sda_oe_q;
  assign bus.reg_addr   = ptr_q;
  assign bus.reg_wdata  = reg_wdata_q;
  assign bus.reg_we     = reg_we_q;
  assign bus.reg_re     = reg_re_q;
  assign bus.busy       = busy_q;
  assign bus.stop_pulse = stop_pulse_q;

endmodule

`default_nettype wire
